dmem_arbiter: RTL and testbench

// Two-requester arbiter for data-memory port A: requester 0 is the core load/store path, requester 1 is the program loader/debug master.

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : round-robin arbiter of core and loader onto data-memory port A
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int DEPTH  = 16384,
    parameter int RD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [1:0]               req_i,
    input  logic [1:0][DW/8-1:0]     we_i,
    input  logic [1:0][AW-1:0]       addr_i,
    input  logic [1:0][DW-1:0]       wdata_i,
    output logic [1:0]               gnt_o,
    output logic [1:0]               rvalid_o,
    output logic [DW-1:0]            rdata_o,
    output logic                     err_o,
    output logic [DW/8-1:0]          mem_we_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DW-1:0]            mem_din_o,
    input  logic [DW-1:0]            mem_dout_i
);

    // One past the last valid byte address; one bit wider than AW so it never wraps.
    localparam logic [AW:0] C_LIMIT = (AW+1)'(longint'(DEPTH) * longint'(DW / 8));

    typedef struct packed {
        logic valid;
        logic id;
        logic is_read;
        logic err;
    } rsp_t;

    logic                   prio_q, prio_d;
    logic [AW-1:0]          addr_hold_q, addr_hold_d;
    logic [DW-1:0]          din_hold_q, din_hold_d;
    rsp_t [RD_LAT-1:0]      pipe_q;
    rsp_t                   rsp_d;
    rsp_t                   rsp_tail;
    logic                   sel;
    logic                   any_gnt;
    logic                   oor;
    logic                   out_valid;

    always_comb begin
        gnt_o       = 2'b00;
        sel         = 1'b0;
        if (rstn_i) begin
            case (req_i)
                2'b01:   begin gnt_o = 2'b01; sel = 1'b0;   end
                2'b10:   begin gnt_o = 2'b10; sel = 1'b1;   end
                2'b11:   begin gnt_o = prio_q ? 2'b10 : 2'b01; sel = prio_q; end
                default: begin gnt_o = 2'b00; sel = 1'b0;   end
            endcase
        end
        any_gnt     = |gnt_o;
        oor         = ({1'b0, addr_i[sel]} >= C_LIMIT);

        // Outside a grant the BRAM address/data stay parked on the last access.
        addr_hold_d = any_gnt ? addr_i[sel]  : addr_hold_q;
        din_hold_d  = any_gnt ? wdata_i[sel] : din_hold_q;
        mem_addr_o  = addr_hold_d;
        mem_din_o   = din_hold_d;
        mem_we_o    = (any_gnt && !oor) ? we_i[sel] : '0;
        prio_d      = any_gnt ? ~sel : prio_q;

        rsp_d.valid   = any_gnt;
        rsp_d.id      = sel;
        rsp_d.is_read = (we_i[sel] == '0);
        rsp_d.err     = oor;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prio_q      <= 1'b0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
            pipe_q      <= '0;
        end else begin
            prio_q      <= prio_d;
            addr_hold_q <= addr_hold_d;
            din_hold_q  <= din_hold_d;
            pipe_q[0]   <= rsp_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Responses are suppressed while reset is held so nothing in flight leaks out.
    always_comb begin
        rsp_tail  = pipe_q[RD_LAT-1];
        out_valid = rsp_tail.valid & rstn_i;
        rvalid_o  = 2'b00;
        if (out_valid) begin
            rvalid_o = rsp_tail.id ? 2'b10 : 2'b01;
        end
        err_o     = out_valid & rsp_tail.err;
        rdata_o   = (out_valid && rsp_tail.is_read && !rsp_tail.err) ? mem_dout_i : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : randomized scoreboard bench for dmem_arbiter with a BRAM model
// Revision        : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 16384;
    localparam int RD_LAT = 3;
    localparam int AB     = $clog2(DEPTH) + 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        req;
    logic [1:0][3:0]   we;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic [3:0]        mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_din_o;
    logic [31:0]       mem_dout;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_din_o  (mem_din_o),
        .mem_dout_i (mem_dout)
    );

    // ---------------- BRAM environment model ----------------
    logic [31:0] bram    [DEPTH];
    logic [31:0] rd_pipe [RD_LAT];
    logic        load_mem;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) bram[mem_addr_o[AB-1:2]][8*b +: 8] <= mem_din_o[8*b +: 8];
        end
        rd_pipe[0] <= bram[mem_addr_o[AB-1:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RD_LAT-1];

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          due;
        logic [1:0]  rv;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [DEPTH];
    logic        p_req   [2];
    logic [3:0]  p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic        ptr;
    logic [31:0] last_addr, last_din;
    logic [1:0]  last_gnt;
    int          cyc = 0;
    int          pulses = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model();
        int          win;
        logic        inr;
        exp_t        e;
        logic [31:0] a;
        logic [AB-3:0] idx;
        if (!rstn) begin
            chk("gnt_in_reset", 32'(gnt_o), 32'd0);
            chk("mem_we_in_reset", 32'(mem_we_o), 32'd0);
            ptr = 1'b0; last_addr = '0; last_din = '0; last_gnt = '0;
            return;
        end
        win = -1;
        if (p_req[0] && p_req[1]) win = ptr ? 1 : 0;
        else if (p_req[0])        win = 0;
        else if (p_req[1])        win = 1;
        last_gnt = gnt_o;
        if (win < 0) begin
            chk("gnt_idle", 32'(gnt_o), 32'd0);
            chk("mem_we_idle", 32'(mem_we_o), 32'd0);
            chk("addr_hold", mem_addr_o, last_addr);
            chk("din_hold", mem_din_o, last_din);
            return;
        end
        a   = p_addr[win];
        inr = (64'(a) < 64'(DEPTH) * 64'd4);
        chk("gnt", 32'(gnt_o), 32'd1 << win);
        chk("mem_addr", mem_addr_o, a);
        chk("mem_din", mem_din_o, p_wdata[win]);
        chk("mem_we", 32'(mem_we_o), inr ? 32'(p_we[win]) : 32'd0);
        idx    = a[AB-1:2];
        e.due  = cyc + RD_LAT;
        e.rv   = (win == 1) ? 2'b10 : 2'b01;
        e.err  = !inr;
        e.data = (inr && p_we[win] == 4'd0) ? ref_mem[idx] : 32'd0;
        if (inr)
            for (int b = 0; b < 4; b++)
                if (p_we[win][b]) ref_mem[idx][8*b +: 8] = p_wdata[win][8*b +: 8];
        sbq.push_back(e);
        p_req[win] = 1'b0;
        ptr        = (win == 0);
        last_addr  = a;
        last_din   = p_wdata[win];
    endtask

    // Response monitor: pops the scoreboard whenever a response is due or seen.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            chk("rvalid_in_reset", 32'(rvalid_o), 32'd0);
            sbq.delete();
        end else begin
            if (rvalid_o != 2'b00) pulses++;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("rvalid", 32'(rvalid_o), 32'(e.rv));
                chk("rdata", rdata_o, e.data);
                chk("err", 32'(err_o), 32'(e.err));
            end else if (rvalid_o != 2'b00) begin
                chk("rvalid_unexpected", 32'(rvalid_o), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            req[i]   = p_req[i];
            we[i]    = p_we[i];
            addr[i]  = p_addr[i];
            wdata[i] = p_wdata[i];
        end
        @(negedge clk);
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input int id, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 8 && p_req[id]; k++) step();
        if (p_req[id]) chk("issue_timeout", 32'd1, 32'd0);
        p_req[id] = 1'b1; p_we[id] = w; p_addr[id] = a; p_wdata[id] = d;
    endtask

    task automatic reset_cycle();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h10000 + $urandom_range(0, 255);
        if (r == 1) return 32'hFFFC + $urandom_range(0, 3);
        if (r == 2) return $urandom;
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        int base;
        rstn = 1'b0; load_mem = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        ptr = 1'b0; last_addr = '0; last_din = '0; last_gnt = '0;
        for (int i = 0; i < 2; i++) begin
            p_req[i] = 1'b0; p_we[i] = '0; p_addr[i] = '0; p_wdata[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        @(posedge clk); #1;
        load_mem = 1'b0;
        run(2);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_din", mem_din_o, 32'd0);
        rstn = 1'b1;

        // Core read of the preloaded word at 0x10.
        issue(0, 4'b0000, 32'h10, 32'h0); step();
        run(RD_LAT + 1);

        // Both requesters every cycle straight out of reset: strict alternation.
        reset_cycle();
        for (int k = 0; k < 6; k++) begin
            for (int id = 0; id < 2; id++)
                if (!p_req[id]) begin
                    p_req[id] = 1'b1; p_we[id] = 4'd0;
                    p_addr[id] = 32'($urandom_range(0, 63)) << 2; p_wdata[id] = $urandom;
                end
            step();
            chk("rr_pattern", 32'(last_gnt), (k % 2 == 1) ? 32'd2 : 32'd1);
        end
        run(RD_LAT + 3);

        // Loader write, core read-back; out-of-range write; top-of-memory boundary.
        issue(1, 4'hF, 32'h20, 32'h12345678); step();
        issue(0, 4'h0, 32'h20, 32'h0);        step();
        issue(0, 4'hF, 32'h10000, 32'hCAFEF00D); step();
        issue(0, 4'h0, 32'h0, 32'h0);         step();
        issue(0, 4'hF, 32'hFFFC, 32'h0BADCAFE); step();
        issue(0, 4'h0, 32'hFFFC, 32'h0);      step();
        issue(1, 4'h0, 32'h10000, 32'h0);     step();
        // Single-byte write then read-back of the whole word.
        issue(0, 4'b0100, 32'h4, 32'hAABBCCDD); step();
        issue(0, 4'h0, 32'h4, 32'h0);         step();
        run(RD_LAT + 3);

        // Reset after the 2nd of 4 back-to-back reads drops the remaining two.
        base = pulses;
        for (int k = 0; k < 4; k++) begin
            issue(0, 4'h0, 32'(k * 4), 32'h0); step();
        end
        for (int k = 0; k < 20 && pulses < base + 2; k++) step();
        reset_cycle();
        run(RD_LAT + 3);
        chk("pulses_around_reset", 32'(pulses - base), 32'd2);
        issue(0, 4'h0, 32'h8, 32'h0);
        issue(1, 4'h0, 32'hC, 32'h0);
        step();
        chk("ptr_after_reset", 32'(last_gnt), 32'd1);
        run(RD_LAT + 3);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int id = 0; id < 2; id++)
                if (!p_req[id] && $urandom_range(0, 99) < 60) begin
                    p_req[id]   = 1'b1;
                    p_we[id]    = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
                    p_addr[id]  = rand_addr();
                    p_wdata[id] = $urandom;
                end
            if ($urandom_range(0, 199) == 0) reset_cycle();
            else step();
        end
        for (int k = 0; k < 10 && (p_req[0] || p_req[1]); k++) step();
        run(RD_LAT + 4);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
